imem_arbiter: RTL and testbench
===============================

Name: imem_arbiter

Overview:
Shares the single instruction memory port between the 2-wide fetch stage and a loader/debug requester that reads and writes program words. Fetch has priority, and a starvation guard guarantees the loader a slot. A halt state machine drains fetch traffic and gives the loader exclusive memory ownership for bulk program loading. The block sits between fetch and inst_rom; the memory has a fixed 1-cycle read latency and no valid signal of its own.

Parameters:
XLEN, 32, data/address width
STARVE_LIMIT, 4, consecutive denied loader cycles before the loader is forced to win; range 1..15

Ports:
clk  input  1  clock
reset  input  1  reset
f_req  input  1  fetch read request (2 words)
f_addr0  input  XLEN  fetch slot-0 address
f_addr1  input  XLEN  fetch slot-1 address
f_flush  input  1  flush/redirect from fetch control
f_gnt  output  1  fetch request accepted this cycle
f_rsp_valid  output  1  fetch response valid
f_rsp_pc  output  2xXLEN packed [1:0][XLEN-1:0]  addresses of the returned words
f_rsp_data0  output  XLEN  slot-0 instruction
f_rsp_data1  output  XLEN  slot-1 instruction
l_req  input  1  loader request
l_we  input  1  1 = write, 0 = read
l_addr  input  XLEN  loader word address
l_wdata  input  XLEN  loader write data
l_gnt  output  1  loader request accepted
l_rsp_valid  output  1  loader read data or write acknowledge
l_rsp_data  output  XLEN  loader read data (0 on write acknowledge)
halt_req  input  1  level request for exclusive loader mode
halt_ack  output  1  exclusive mode active
mem_addr0  output  XLEN  memory address 0
mem_addr1  output  XLEN  memory address 1
mem_ren  output  1  memory read enable
mem_wen  output  1  memory write enable
mem_wdata  output  XLEN  memory write data
mem_rdata0  input  XLEN  memory read data 0, valid 1 cycle after mem_ren
mem_rdata1  input  XLEN  memory read data 1

Behaviour:
- Clock is clk. Reset is asynchronous and active-high and is named reset. Reset forces state RUN, starve_cnt=0 and all in-flight tags to 0. As a result f_rsp_valid=0, l_rsp_valid=0 and halt_ack=0 immediately. Reset mid-transaction drops the response.
- States:
  - RUN: normal arbitration.
  - DRAIN: fetch blocked, waiting for the in-flight fetch response.
  - HALTED: loader-exclusive mode.
- State transitions:
  - RUN to DRAIN when halt_req=1 and a fetch response is in flight this cycle.
  - RUN to HALTED when halt_req=1 and no fetch response is in flight.
  - DRAIN to HALTED on the next cycle. With 1-cycle latency, DRAIN lasts exactly 1 cycle.
  - HALTED or DRAIN to RUN when halt_req=0.
- Grant rules in RUN, all combinational:
  - loader_win = l_req && (!f_req || f_flush || starve_cnt==STARVE_LIMIT).
  - l_gnt = loader_win.
  - f_gnt = f_req && !f_flush && !loader_win.
- Grant rules in DRAIN and HALTED: f_gnt=0 and l_gnt=l_req.
- At most one grant per cycle.
- Memory drive:
  - Fetch grant: mem_addr0=f_addr0, mem_addr1=f_addr1, mem_ren=1.
  - Loader grant: mem_addr0=l_addr, mem_addr1=l_addr+4 (mod 2^XLEN), mem_ren=!l_we, mem_wen=l_we, mem_wdata=l_wdata.
  - No grant: ren=wen=0, addresses and wdata driven 0.
- starve_cnt width is 4 bits. It increments, saturating at STARVE_LIMIT, when l_req && !l_gnt. It clears when l_gnt=1 or l_req=0.
- In-flight tags registered on a grant:
  - f_inflight and f_rsp_pc[0]/[1] = f_addr0/f_addr1.
  - l_inflight and l_was_write.
- Fetch response, in the cycle after f_gnt:
  - f_rsp_valid = f_inflight && !f_flush. A flush in the response cycle suppresses the response.
  - f_rsp_data0/1 = mem_rdata0/1.
- Loader response, in the cycle after l_gnt:
  - l_rsp_valid = l_inflight.
  - l_rsp_data = l_was_write ? 0 : mem_rdata0.
  - f_flush does not affect loader responses.
- halt_ack = (state==HALTED), registered.
- A new grant may issue in the same cycle a response returns (fully pipelined, throughput 1 per cycle).
- Simultaneous halt_req and f_req in RUN: fetch is still granted that cycle if it wins arbitration. DRAIN then covers that response.
- Address alignment is not checked.

Test Plan:
- Fetch only: f_req=1, f_addr0=0x100, f_addr1=0x104, mem returns 0xAAAA/0xBBBB -> f_gnt=1, mem_ren=1; next cycle f_rsp_valid=1, f_rsp_pc={0x104,0x100}, data 0xAAAA/0xBBBB.
- Starvation, STARVE_LIMIT=4: f_req and l_req held high (read 0x20) -> fetch granted cycles 0-3; l_gnt=1 in cycle 4, starve_cnt cleared; fetch granted again in cycle 5.
- Flush: f_gnt at cycle N, f_flush=1 at N+1 -> f_rsp_valid=0 at N+1, f_gnt=0 at N+1. If l_req is high at N+1, l_gnt=1 that cycle.
- Halt: fetch streaming, halt_req=1 at cycle N -> DRAIN at N+1 (response delivered), halt_ack=1 at N+2, f_gnt=0 while halted. Loader write 0x40 <- 0xDEAD gives mem_wen=1; the following l_rsp_valid=1 carries data 0.
- Release: halt_req=0 while HALTED -> RUN next cycle, halt_ack=0, f_gnt resumes.
- Reset asserted while a fetch is in flight -> f_rsp_valid, l_rsp_valid and halt_ack drop to 0 immediately (asynchronous); no response is delivered after reset.

Source files
------------

// File: rtl/imem_arbiter.sv
// imem_arbiter: shares the single instruction-memory port between the 2-wide
// fetch stage and the loader/debug requester.
//
// Arbitration:
//   - Fetch has priority over the loader.
//   - A starvation counter forces a loader win after STARVE_LIMIT denials.
//   - A halt FSM (RUN/DRAIN/HALTED) drains fetch traffic and then gives the
//     loader exclusive ownership of the memory.
//
// The memory has a fixed 1-cycle read latency. Responses are therefore
// formed from tags registered at grant time plus the raw memory read data.
//
// Ports:
//   clk, reset                    clock, async active-high reset
//   f_req/f_addr0/f_addr1/f_flush fetch request side
//   f_gnt, f_rsp_*                fetch grant and response
//   l_req/l_we/l_addr/l_wdata     loader request side
//   l_gnt, l_rsp_*                loader grant and response
//   halt_req/halt_ack             exclusive loader mode handshake
//   mem_*                         instruction memory port
module imem_arbiter #(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 f_req,
    input  logic [XLEN-1:0]      f_addr0,
    input  logic [XLEN-1:0]      f_addr1,
    input  logic                 f_flush,
    output logic                 f_gnt,
    output logic                 f_rsp_valid,
    output logic [1:0][XLEN-1:0] f_rsp_pc,
    output logic [XLEN-1:0]      f_rsp_data0,
    output logic [XLEN-1:0]      f_rsp_data1,
    input  logic                 l_req,
    input  logic                 l_we,
    input  logic [XLEN-1:0]      l_addr,
    input  logic [XLEN-1:0]      l_wdata,
    output logic                 l_gnt,
    output logic                 l_rsp_valid,
    output logic [XLEN-1:0]      l_rsp_data,
    input  logic                 halt_req,
    output logic                 halt_ack,
    output logic [XLEN-1:0]      mem_addr0,
    output logic [XLEN-1:0]      mem_addr1,
    output logic                 mem_ren,
    output logic                 mem_wen,
    output logic [XLEN-1:0]      mem_wdata,
    input  logic [XLEN-1:0]      mem_rdata0,
    input  logic [XLEN-1:0]      mem_rdata1
);

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t     state, state_nxt;
    logic [3:0] starve_cnt;
    logic       f_inflight;
    logic       l_inflight;
    logic       l_was_write;
    logic       loader_win;

    // ------------------------------------------------------------------
    // Next state and grants
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt  = state;
        loader_win = 1'b0;
        f_gnt      = 1'b0;
        l_gnt      = 1'b0;
        case (state)
            RUN: begin
                loader_win = l_req && (!f_req || f_flush || starve_cnt == LIMIT);
                l_gnt      = loader_win;
                f_gnt      = f_req && !f_flush && !loader_win;
                // A grant issued this cycle also counts as in flight, so that
                // DRAIN covers a fetch accepted together with halt_req.
                if (halt_req)
                    state_nxt = (f_inflight || f_gnt) ? DRAIN : HALTED;
            end
            DRAIN: begin
                l_gnt     = l_req;
                state_nxt = halt_req ? HALTED : RUN;
            end
            HALTED: begin
                l_gnt     = l_req;
                state_nxt = halt_req ? HALTED : RUN;
            end
            default: state_nxt = RUN;
        endcase
    end

    // ------------------------------------------------------------------
    // Memory port drive: idle cycles drive everything to 0
    // ------------------------------------------------------------------
    always_comb begin
        mem_addr0 = '0;
        mem_addr1 = '0;
        mem_ren   = 1'b0;
        mem_wen   = 1'b0;
        mem_wdata = '0;
        if (f_gnt) begin
            mem_addr0 = f_addr0;
            mem_addr1 = f_addr1;
            mem_ren   = 1'b1;
        end else if (l_gnt) begin
            mem_addr0 = l_addr;
            mem_addr1 = l_addr + XLEN'(4);
            mem_ren   = !l_we;
            mem_wen   = l_we;
            mem_wdata = l_wdata;
        end
    end

    // ------------------------------------------------------------------
    // State, starvation counter, in-flight tags
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= RUN;
            starve_cnt  <= '0;
            f_inflight  <= 1'b0;
            l_inflight  <= 1'b0;
            l_was_write <= 1'b0;
            f_rsp_pc    <= '0;
        end else begin
            state <= state_nxt;

            if (l_req && !l_gnt)
                starve_cnt <= (starve_cnt >= LIMIT) ? LIMIT : starve_cnt + 4'd1;
            else
                starve_cnt <= '0;

            f_inflight <= f_gnt;
            if (f_gnt) begin
                f_rsp_pc[0] <= f_addr0;
                f_rsp_pc[1] <= f_addr1;
            end

            l_inflight <= l_gnt;
            if (l_gnt)
                l_was_write <= l_we;
        end
    end

    // ------------------------------------------------------------------
    // Responses: memory data is valid the cycle after the grant
    // ------------------------------------------------------------------
    assign f_rsp_valid = f_inflight && !f_flush;
    assign f_rsp_data0 = mem_rdata0;
    assign f_rsp_data1 = mem_rdata1;

    assign l_rsp_valid = l_inflight;
    assign l_rsp_data  = l_was_write ? '0 : mem_rdata0;

    assign halt_ack = (state == HALTED);

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed testbench for imem_arbiter with a 1-cycle-latency memory model.
module tb_imem_arbiter;

    localparam int XLEN = 32;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 f_req, f_flush;
    logic [XLEN-1:0]      f_addr0, f_addr1;
    logic                 f_gnt, f_rsp_valid;
    logic [1:0][XLEN-1:0] f_rsp_pc;
    logic [XLEN-1:0]      f_rsp_data0, f_rsp_data1;
    logic                 l_req, l_we;
    logic [XLEN-1:0]      l_addr, l_wdata;
    logic                 l_gnt, l_rsp_valid;
    logic [XLEN-1:0]      l_rsp_data;
    logic                 halt_req, halt_ack;
    logic [XLEN-1:0]      mem_addr0, mem_addr1, mem_wdata;
    logic                 mem_ren, mem_wen;
    logic [XLEN-1:0]      mem_rdata0, mem_rdata1;

    int checks = 0;
    int errors = 0;

    logic [XLEN-1:0] mem [256];

    always #5 clk = ~clk;

    imem_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .f_req(f_req), .f_addr0(f_addr0), .f_addr1(f_addr1), .f_flush(f_flush),
        .f_gnt(f_gnt), .f_rsp_valid(f_rsp_valid), .f_rsp_pc(f_rsp_pc),
        .f_rsp_data0(f_rsp_data0), .f_rsp_data1(f_rsp_data1),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_gnt(l_gnt), .l_rsp_valid(l_rsp_valid), .l_rsp_data(l_rsp_data),
        .halt_req(halt_req), .halt_ack(halt_ack),
        .mem_addr0(mem_addr0), .mem_addr1(mem_addr1), .mem_ren(mem_ren),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata),
        .mem_rdata0(mem_rdata0), .mem_rdata1(mem_rdata1)
    );

    // inst_rom stand-in: synchronous read, 1-cycle latency, word indexed
    always @(posedge clk) begin
        if (mem_ren) begin
            mem_rdata0 <= mem[mem_addr0[9:2]];
            mem_rdata1 <= mem[mem_addr1[9:2]];
        end
        if (mem_wen) mem[mem_addr0[9:2]] <= mem_wdata;
    end

    // Advance one cycle; inputs change and outputs are sampled 1ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        f_req = 0; f_flush = 0; f_addr0 = 0; f_addr1 = 0;
        l_req = 0; l_we = 0; l_addr = 0; l_wdata = 0; halt_req = 0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1;
        #1;
        checks++; if (f_rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_f_rsp_valid got %b exp 0", f_rsp_valid); end
        checks++; if (l_rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_l_rsp_valid got %b exp 0", l_rsp_valid); end
        checks++; if (halt_ack !== 1'b0) begin errors++; $display("FAIL reset_halt_ack got %b exp 0", halt_ack); end
        step(); step();
        reset = 0;
        step();
        checks++; if ({f_gnt, l_gnt, mem_ren, mem_wen} !== 4'b0) begin errors++; $display("FAIL idle_outputs got %b exp 0000", {f_gnt, l_gnt, mem_ren, mem_wen}); end
        checks++; if (mem_addr0 !== 0 || mem_wdata !== 0) begin errors++; $display("FAIL idle_addr got %h/%h exp 0/0", mem_addr0, mem_wdata); end
    endtask

    task automatic test_fetch();
        f_req = 1; f_addr0 = 32'h100; f_addr1 = 32'h104;
        #1;
        checks++; if ({f_gnt, l_gnt, mem_ren, mem_wen} !== 4'b1010) begin errors++; $display("FAIL fetch_grant got %b exp 1010", {f_gnt, l_gnt, mem_ren, mem_wen}); end
        checks++; if (mem_addr0 !== 32'h100 || mem_addr1 !== 32'h104) begin errors++; $display("FAIL fetch_mem_addr got %h/%h exp 100/104", mem_addr0, mem_addr1); end
        step();
        f_req = 0;
        #1;
        checks++; if (f_rsp_valid !== 1'b1) begin errors++; $display("FAIL fetch_rsp_valid got %b exp 1", f_rsp_valid); end
        checks++; if (f_rsp_pc !== {32'h104, 32'h100}) begin errors++; $display("FAIL fetch_rsp_pc got %h exp %h", f_rsp_pc, {32'h104, 32'h100}); end
        checks++; if (f_rsp_data0 !== 32'hAAAA || f_rsp_data1 !== 32'hBBBB) begin errors++; $display("FAIL fetch_rsp_data got %h/%h exp aaaa/bbbb", f_rsp_data0, f_rsp_data1); end
        step();
        checks++; if (f_rsp_valid !== 1'b0) begin errors++; $display("FAIL fetch_rsp_single got %b exp 0", f_rsp_valid); end
    endtask

    task automatic test_back_to_back();
        logic [XLEN-1:0] a0 [3];
        logic [XLEN-1:0] a1 [3];
        logic [XLEN-1:0] d0 [3];
        logic [XLEN-1:0] d1 [3];
        a0 = '{32'h100, 32'h104, 32'h20};
        a1 = '{32'h104, 32'h100, 32'h24};
        d0 = '{32'hAAAA, 32'hBBBB, 32'h1234};
        d1 = '{32'hBBBB, 32'hAAAA, 32'h5678};
        for (int i = 0; i < 4; i++) begin
            if (i < 3) begin f_req = 1; f_addr0 = a0[i]; f_addr1 = a1[i]; end
            else f_req = 0;
            #1;
            if (i < 3) begin
                checks++; if (f_gnt !== 1'b1) begin errors++; $display("FAIL b2b_gnt[%0d] got %b exp 1", i, f_gnt); end
            end
            if (i > 0) begin
                checks++; if (f_rsp_valid !== 1'b1 || f_rsp_pc !== {a1[i-1], a0[i-1]}) begin errors++; $display("FAIL b2b_rsp[%0d] got %b %h exp 1 %h", i, f_rsp_valid, f_rsp_pc, {a1[i-1], a0[i-1]}); end
                checks++; if (f_rsp_data0 !== d0[i-1] || f_rsp_data1 !== d1[i-1]) begin errors++; $display("FAIL b2b_data[%0d] got %h/%h exp %h/%h", i, f_rsp_data0, f_rsp_data1, d0[i-1], d1[i-1]); end
            end
            step();
        end
        idle();
    endtask

    task automatic test_starvation();
        f_req = 1; f_addr0 = 32'h100; f_addr1 = 32'h104;
        l_req = 1; l_we = 0; l_addr = 32'h20;
        for (int c = 0; c < 7; c++) begin
            #1;
            checks++; if (l_gnt !== (c == 4) || f_gnt !== (c != 4)) begin errors++; $display("FAIL starve_cyc%0d got f%b l%b exp f%b l%b", c, f_gnt, l_gnt, c != 4, c == 4); end
            if (c == 4) begin
                checks++; if (mem_addr0 !== 32'h20 || mem_addr1 !== 32'h24 || mem_ren !== 1'b1) begin errors++; $display("FAIL starve_mem got %h/%h ren %b exp 20/24 ren 1", mem_addr0, mem_addr1, mem_ren); end
            end
            if (c == 5) begin
                checks++; if (l_rsp_valid !== 1'b1 || l_rsp_data !== 32'h1234) begin errors++; $display("FAIL starve_lrsp got %b %h exp 1 1234", l_rsp_valid, l_rsp_data); end
                checks++; if (f_rsp_valid !== 1'b0) begin errors++; $display("FAIL starve_no_frsp got %b exp 0", f_rsp_valid); end
            end
            step();
        end
        idle();
        step();
    endtask

    task automatic test_flush();
        f_req = 1; f_addr0 = 32'h100; f_addr1 = 32'h104;
        #1;
        checks++; if (f_gnt !== 1'b1) begin errors++; $display("FAIL flush_pre_gnt got %b exp 1", f_gnt); end
        step();
        f_flush = 1; l_req = 1; l_we = 0; l_addr = 32'h20;
        #1;
        checks++; if (f_rsp_valid !== 1'b0) begin errors++; $display("FAIL flush_rsp_suppressed got %b exp 0", f_rsp_valid); end
        checks++; if (f_gnt !== 1'b0 || l_gnt !== 1'b1) begin errors++; $display("FAIL flush_grants got f%b l%b exp f0 l1", f_gnt, l_gnt); end
        step();
        idle();
        #1;
        checks++; if (l_rsp_valid !== 1'b1 || l_rsp_data !== 32'h1234) begin errors++; $display("FAIL flush_lrsp got %b %h exp 1 1234", l_rsp_valid, l_rsp_data); end
        checks++; if (f_rsp_valid !== 1'b0) begin errors++; $display("FAIL flush_after got %b exp 0", f_rsp_valid); end
        step();
    endtask

    task automatic test_halt();
        f_req = 1; f_addr0 = 32'h100; f_addr1 = 32'h104;
        step();
        // cycle N: fetch streaming, halt requested
        halt_req = 1;
        #1;
        checks++; if (f_gnt !== 1'b1 || halt_ack !== 1'b0) begin errors++; $display("FAIL halt_n got gnt%b ack%b exp 1 0", f_gnt, halt_ack); end
        step();
        // N+1: DRAIN, last fetch response delivered
        checks++; if (f_gnt !== 1'b0 || f_rsp_valid !== 1'b1 || halt_ack !== 1'b0) begin errors++; $display("FAIL halt_drain got gnt%b rsp%b ack%b exp 0 1 0", f_gnt, f_rsp_valid, halt_ack); end
        step();
        checks++; if (halt_ack !== 1'b1 || f_gnt !== 1'b0 || f_rsp_valid !== 1'b0) begin errors++; $display("FAIL halt_ack got ack%b gnt%b rsp%b exp 1 0 0", halt_ack, f_gnt, f_rsp_valid); end
        l_req = 1; l_we = 1; l_addr = 32'h40; l_wdata = 32'hDEAD;
        #1;
        checks++; if ({l_gnt, mem_wen, mem_ren} !== 3'b110 || mem_addr0 !== 32'h40 || mem_wdata !== 32'hDEAD) begin errors++; $display("FAIL halt_write got %b %h %h exp 110 40 dead", {l_gnt, mem_wen, mem_ren}, mem_addr0, mem_wdata); end
        step();
        l_we = 0;
        #1;
        checks++; if (l_rsp_valid !== 1'b1 || l_rsp_data !== 32'h0) begin errors++; $display("FAIL halt_wack got %b %h exp 1 0", l_rsp_valid, l_rsp_data); end
        step();
        l_req = 0;
        #1;
        checks++; if (l_rsp_valid !== 1'b1 || l_rsp_data !== 32'hDEAD) begin errors++; $display("FAIL halt_readback got %b %h exp 1 dead", l_rsp_valid, l_rsp_data); end
        // release
        halt_req = 0;
        #1;
        checks++; if (halt_ack !== 1'b1 || f_gnt !== 1'b0) begin errors++; $display("FAIL release_same got ack%b gnt%b exp 1 0", halt_ack, f_gnt); end
        step();
        checks++; if (halt_ack !== 1'b0 || f_gnt !== 1'b1) begin errors++; $display("FAIL release_next got ack%b gnt%b exp 0 1", halt_ack, f_gnt); end
        idle();
        step(); step();
    endtask

    task automatic test_async_reset();
        // Fetch in flight, then reset between edges
        f_req = 1; f_addr0 = 32'h100; f_addr1 = 32'h104;
        step();
        f_req = 0;
        #1;
        checks++; if (f_rsp_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_frsp got %b exp 1", f_rsp_valid); end
        reset = 1;
        #1;
        checks++; if (f_rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_async_frsp got %b exp 0", f_rsp_valid); end
        step();
        reset = 0;
        // Halted with a loader read in flight, then reset
        halt_req = 1;
        step(); step();
        l_req = 1; l_we = 0; l_addr = 32'h20;
        step();
        l_req = 0;
        #1;
        checks++; if (l_rsp_valid !== 1'b1 || halt_ack !== 1'b1) begin errors++; $display("FAIL rst_pre_l got rsp%b ack%b exp 1 1", l_rsp_valid, halt_ack); end
        halt_req = 0;
        reset = 1;
        #1;
        checks++; if (l_rsp_valid !== 1'b0 || halt_ack !== 1'b0) begin errors++; $display("FAIL rst_async_l got rsp%b ack%b exp 0 0", l_rsp_valid, halt_ack); end
        step();
        reset = 0;
        step();
        checks++; if (f_rsp_valid !== 1'b0 || l_rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_no_late_rsp got f%b l%b exp 0 0", f_rsp_valid, l_rsp_valid); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[32'h100 >> 2] = 32'hAAAA;
        mem[32'h104 >> 2] = 32'hBBBB;
        mem[32'h20 >> 2]  = 32'h1234;
        mem[32'h24 >> 2]  = 32'h5678;
        mem_rdata0 = 0;
        mem_rdata1 = 0;
        test_reset();
        test_fetch();
        test_back_to_back();
        test_starvation();
        test_flush();
        test_halt();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
